// File: rtl/picorv32_mem_copier.sv
// picorv32_mem_copier: word-by-word memory copy engine mastering the PicoRV32 native bus.
// Ports: clk, resetn | cmd_valid/ready, cmd_src/dst/len | mem_* native bus | busy, done, err.
module picorv32_mem_copier #(
   parameter int LEN_WIDTH = 16,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [31:0]          cmd_src,
   input  logic [31:0]          cmd_dst,
   input  logic [LEN_WIDTH-1:0] cmd_len,
   output logic                 mem_valid,
   output logic                 mem_instr,
   input  logic                 mem_ready,
   output logic [31:0]          mem_addr,
   output logic [31:0]          mem_wdata,
   output logic [3:0]           mem_wstrb,
   input  logic [31:0]          mem_rdata,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_FINISH
   } state_t;

   localparam bit          TMO_EN   = (TIMEOUT > 0);
   localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT - 1) : 32'd0;

   state_t r_state;
   state_t w_next;

   logic                 r_mem_valid;
   logic [31:0]          r_mem_addr;
   logic [31:0]          r_mem_wdata;
   logic [3:0]           r_mem_wstrb;
   logic [31:0]          r_src;
   logic [31:0]          r_dst;
   logic [31:0]          r_data;
   logic [31:0]          r_tmo;
   logic [LEN_WIDTH-1:0] r_len;
   logic                 r_err;

   logic w_idle;
   logic w_accept;
   logic w_hs;
   logic w_stall;
   logic w_tmo;
   logic w_last;
   logic w_len_zero;
   logic w_launch;

   assign w_idle     = (r_state == S_IDLE);
   assign cmd_ready  = w_idle & resetn;
   assign w_accept   = cmd_valid & cmd_ready;
   assign w_hs       = r_mem_valid & mem_ready;
   assign w_stall    = r_mem_valid & ~mem_ready;
   // Fires on the stalled cycle that would bring the count up to TIMEOUT.
   assign w_tmo      = TMO_EN && w_stall && (r_tmo == TMO_LAST);
   assign w_last     = (r_len == LEN_WIDTH'(1));
   assign w_len_zero = (cmd_len == '0);

   always_comb begin
      w_next   = r_state;
      w_launch = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept)
               w_next = w_len_zero ? S_FINISH : S_READ;
         end
         S_READ, S_WRITE: begin
            if (w_tmo)
               w_next = S_FINISH;
            else if (w_hs) begin
               if (r_state == S_READ)
                  w_next = S_WRITE;
               else
                  w_next = w_last ? S_FINISH : S_READ;
            end
            // A low mem_valid here is the one-cycle gap after a handshake.
            else if (!r_mem_valid)
               w_launch = 1'b1;
         end
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_mem_valid <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= '0;
         r_src       <= '0;
         r_dst       <= '0;
         r_data      <= '0;
         r_tmo       <= '0;
         r_len       <= '0;
         r_err       <= 1'b0;
      end else if (w_accept) begin
         r_src <= {cmd_src[31:2], 2'b00};
         r_dst <= {cmd_dst[31:2], 2'b00};
         r_len <= cmd_len;
         r_err <= 1'b0;
         r_tmo <= '0;
         if (!w_len_zero) begin
            r_mem_valid <= 1'b1;
            r_mem_addr  <= {cmd_src[31:2], 2'b00};
            r_mem_wstrb <= 4'h0;
         end
      end else if (w_tmo) begin
         r_mem_valid <= 1'b0;
         r_err       <= 1'b1;
         r_tmo       <= '0;
      end else if (w_hs) begin
         r_mem_valid <= 1'b0;
         r_tmo       <= '0;
         if (r_state == S_READ)
            r_data <= mem_rdata;
         else begin
            r_src <= r_src + 32'd4;
            r_dst <= r_dst + 32'd4;
            r_len <= r_len - LEN_WIDTH'(1);
         end
      end else if (w_launch) begin
         r_mem_valid <= 1'b1;
         if (r_state == S_READ) begin
            r_mem_addr  <= r_src;
            r_mem_wstrb <= 4'h0;
         end else begin
            r_mem_addr  <= r_dst;
            r_mem_wdata <= r_data;
            r_mem_wstrb <= 4'hF;
         end
      end else if (w_stall && TMO_EN) begin
         r_tmo <= r_tmo + 32'd1;
      end
   end

   assign mem_valid = r_mem_valid;
   assign mem_instr = 1'b0;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_wstrb = r_mem_wstrb;
   assign busy      = ~w_idle;
   assign done      = (r_state == S_FINISH);
   assign err       = r_err;

endmodule

// File: tb/tb_picorv32_mem_copier.sv
// tb_picorv32_mem_copier: directed table plus random copies against a word-level copy model.
// Ports: none (drives the picorv32_mem_copier with a latency-programmable memory responder).
`timescale 1ns/1ps
module tb_picorv32_mem_copier;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_src = '0;
   logic [31:0] cmd_dst = '0;
   logic [15:0] cmd_len = '0;
   logic        mem_valid;
   logic        mem_instr;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata = '0;
   logic        busy;
   logic        done;
   logic        err;

   picorv32_mem_copier #(.LEN_WIDTH(16), .TIMEOUT(TMO)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      int          lat;
   } acc_t;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int          len;
      int          lat;
      int          exp_done;
      logic        exp_err;
   } vec_t;

   acc_t        log_q[$];
   acc_t        exp_q[$];
   logic [31:0] wmem [logic [31:0]];
   logic [31:0] rmem [logic [31:0]];
   int          fix_lat = 1;
   int          stab_err = 0;
   int          vectors = 0;
   int          miscompares = 0;

   function automatic logic [31:0] seedv(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] rd_w(logic [31:0] a);
      return wmem.exists(a) ? wmem[a] : seedv(a);
   endfunction

   function automatic logic [31:0] rd_r(logic [31:0] a);
      return rmem.exists(a) ? rmem[a] : seedv(a);
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Memory responder: ready after 'lat' stalled cycles, logs every handshake.
   initial begin : resp
      bit          active;
      int          wcnt;
      int          lat;
      logic [31:0] a0;
      logic [31:0] d0;
      logic [3:0]  s0;
      active = 0;
      wcnt = 0;
      lat = 0;
      forever begin
         @(negedge clk);
         if (mem_ready) begin
            mem_ready = 1'b0;
            if (mem_valid) stab_err++;
         end else if (mem_valid && resetn) begin
            if (!active) begin
               active = 1;
               wcnt = 0;
               a0 = mem_addr;
               d0 = mem_wdata;
               s0 = mem_wstrb;
               lat = (fix_lat < 0) ? int'($urandom_range(0, 3)) : fix_lat;
            end else if (mem_addr !== a0 || mem_wstrb !== s0 ||
                         (s0 != 4'h0 && mem_wdata !== d0)) begin
               stab_err++;
            end
            if (wcnt == lat) begin
               mem_ready = 1'b1;
               active = 0;
               if (s0 == 4'h0) begin
                  mem_rdata = rd_w(a0);
                  log_q.push_back('{a0, 4'h0, 32'h0, lat});
               end else begin
                  wmem[a0] = d0;
                  log_q.push_back('{a0, s0, d0, lat});
               end
            end else begin
               wcnt++;
            end
         end else if (!mem_valid) begin
            active = 0;
         end
      end
   end

   // Reference: a plain sequential word copy over the model memory.
   task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int len);
      logic [31:0] sp;
      logic [31:0] dp;
      logic [31:0] v;
      sp = s & ~32'h3;
      dp = d & ~32'h3;
      for (int i = 0; i < len; i++) begin
         v = rd_r(sp);
         exp_q.push_back('{sp, 4'h0, 32'h0, 0});
         exp_q.push_back('{dp, 4'hF, v, 0});
         rmem[dp] = v;
         sp += 32'd4;
         dp += 32'd4;
      end
   endtask

   task automatic check_log(string name);
      int bad;
      bad = -1;
      vectors++;
      if (log_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL %s: got %0d accesses, expected %0d", name, log_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i])
            if (bad < 0 && (log_q[i].addr !== exp_q[i].addr ||
                log_q[i].wstrb !== exp_q[i].wstrb ||
                log_q[i].wdata !== exp_q[i].wdata))
               bad = i;
         if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s: access %0d got a=%08h s=%h d=%08h, expected a=%08h s=%h d=%08h",
                     name, bad, log_q[bad].addr, log_q[bad].wstrb, log_q[bad].wdata,
                     exp_q[bad].addr, exp_q[bad].wstrb, exp_q[bad].wdata);
         end
      end
   endtask

   task automatic check_mem(string name);
      int          bad;
      logic [31:0] ba;
      bad = 0;
      ba = '0;
      if (rmem.size() != wmem.size()) bad++;
      foreach (rmem[k])
         if (!wmem.exists(k) || wmem[k] !== rmem[k]) begin
            bad++;
            ba = k;
         end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL %s: %0d word(s) differ, e.g. addr %08h got %08h expected %08h",
                  name, bad, ba, rd_w(ba), rd_r(ba));
      end
   endtask

   task automatic wait_done(output int dc, output logic de);
      dc = -1;
      de = 1'bx;
      for (int c = 1; c <= 3000; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            dc = c;
            de = err;
            break;
         end
      end
   endtask

   task automatic check_post(string name, logic exp_err);
      @(negedge clk);
      check({name, "_post"}, {60'd0, done, busy, cmd_ready, err}, {60'd0, 3'b001, exp_err});
   endtask

   task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input int len,
                          input int lat, output int dc, output logic de);
      log_q = {};
      exp_q = {};
      fix_lat = lat;
      stab_err = 0;
      @(posedge clk);
      #2;
      cmd_src = s;
      cmd_dst = d;
      cmd_len = 16'(len);
      cmd_valid = 1'b1;
      @(negedge clk);
      check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
      @(posedge clk);
      #2;
      cmd_valid = 1'b0;
      wait_done(dc, de);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      vec_t        tbl[6];
      int          dc;
      int          bad;
      int          exp_dc;
      logic        de;
      logic [31:0] s;
      logic [31:0] d;
      int          len;

      tbl[0] = '{32'h0000_0100, 32'h0000_0200, 3, 1, 18, 1'b0};
      tbl[1] = '{32'h0000_0103, 32'hFFFF_FFFC, 2, 1, 12, 1'b0};
      tbl[2] = '{32'h0000_0040, 32'h0000_0080, 0, 1, 1, 1'b0};
      tbl[3] = '{32'h0000_0300, 32'h0000_0400, 1, 0, 4, 1'b0};
      tbl[4] = '{32'h0000_1000, 32'h0000_1004, 4, 2, 32, 1'b0};
      tbl[5] = '{32'h0000_0500, 32'h0000_0600, 5, 1000, 5, 1'b1};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_bus", {mem_addr, mem_wdata}, 64'd0);
      check("reset_ctrl", {57'd0, cmd_ready, mem_valid, mem_instr, busy, done, err, 1'b0},
            64'd0);
      check("reset_wstrb", {60'd0, mem_wstrb}, 64'd0);
      @(posedge clk);
      #2;
      resetn = 1'b1;
      @(negedge clk);
      check("release_ready", {62'd0, cmd_ready, busy}, 64'd2);

      foreach (tbl[i]) begin
         run_cmd(tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].lat, dc, de);
         model_copy(tbl[i].src, tbl[i].dst, tbl[i].exp_err ? 0 : tbl[i].len);
         check($sformatf("row%0d_done_cycle", i), dc, tbl[i].exp_done);
         check($sformatf("row%0d_err", i), {63'd0, de}, {63'd0, tbl[i].exp_err});
         check_log($sformatf("row%0d_log", i));
         check_mem($sformatf("row%0d_mem", i));
         check($sformatf("row%0d_stable", i), stab_err, 0);
         check_post($sformatf("row%0d", i), tbl[i].exp_err);
      end

      repeat (3) @(negedge clk);
      check("err_held", {63'd0, err}, 64'd1);

      log_q = {};
      exp_q = {};
      fix_lat = 0;
      stab_err = 0;
      @(posedge clk);
      #2;
      cmd_src = 32'h700;
      cmd_dst = 32'h800;
      cmd_len = 16'd2;
      cmd_valid = 1'b1;
      @(posedge clk);
      #2;
      cmd_src = 32'h900;
      cmd_dst = 32'hA00;
      cmd_len = 16'd1;
      @(negedge clk);
      check("err_clear_on_accept", {63'd0, err}, 64'd0);
      bad = 0;
      dc = -1;
      for (int c = 1; c <= 200; c++) begin
         if (cmd_ready !== 1'b0) bad++;
         if (done === 1'b1) begin
            dc = c;
            break;
         end
         @(negedge clk);
      end
      check("held_ready_low_busy", bad, 0);
      check("held_a_done_cycle", dc, 8);
      @(negedge clk);
      check("held_ready_after_done", {62'd0, cmd_ready, busy}, 64'd2);
      @(posedge clk);
      #2;
      cmd_valid = 1'b0;
      wait_done(dc, de);
      check("held_b_done_cycle", dc, 4);
      check("held_b_err", {63'd0, de}, 64'd0);
      model_copy(32'h700, 32'h800, 2);
      model_copy(32'h900, 32'hA00, 1);
      check_log("held_log");
      check_mem("held_mem");
      check("held_stable", stab_err, 0);
      check_post("held", 1'b0);

      log_q = {};
      exp_q = {};
      fix_lat = 2;
      stab_err = 0;
      bad = 0;
      @(posedge clk);
      #2;
      cmd_src = 32'hB00;
      cmd_dst = 32'hC00;
      cmd_len = 16'd4;
      cmd_valid = 1'b1;
      @(posedge clk);
      #2;
      cmd_valid = 1'b0;
      @(negedge clk);
      check("rst_in_read", {58'd0, mem_valid, busy, mem_wstrb}, {58'd0, 2'b11, 4'h0});
      if (done) bad++;
      @(posedge clk);
      #2;
      resetn = 1'b0;
      @(negedge clk);
      if (done) bad++;
      @(negedge clk);
      check("rst_forced_ctrl", {58'd0, mem_valid, busy, done, err, cmd_ready, 1'b0}, 64'd0);
      check("rst_forced_bus", {mem_addr, 28'd0, mem_wstrb}, 64'd0);
      @(posedge clk);
      #2;
      resetn = 1'b1;
      @(negedge clk);
      check("rst_release_ready", {62'd0, cmd_ready, busy}, 64'd2);
      if (done) bad++;
      check("rst_no_done", bad, 0);
      check_log("rst_log");
      check_mem("rst_mem");
      run_cmd(32'hB00, 32'hC00, 2, 1, dc, de);
      model_copy(32'hB00, 32'hC00, 2);
      check("rst_new_done_cycle", dc, 12);
      check_log("rst_new_log");
      check_mem("rst_new_mem");
      check_post("rst_new", 1'b0);

      for (int n = 0; n < 25; n++) begin
         s = 32'h2000 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
         d = 32'h2000 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
         len = int'($urandom_range(0, 6));
         run_cmd(s, d, len, -1, dc, de);
         model_copy(s, d, len);
         exp_dc = (len == 0) ? 1 : 0;
         foreach (log_q[i]) exp_dc += log_q[i].lat + 2;
         check($sformatf("rnd%0d_done_cycle", n), dc, exp_dc);
         check($sformatf("rnd%0d_err", n), {63'd0, de}, 64'd0);
         check_log($sformatf("rnd%0d_log", n));
         check_mem($sformatf("rnd%0d_mem", n));
         check($sformatf("rnd%0d_stable", n), stab_err, 0);
         check_post($sformatf("rnd%0d", n), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
